// File: rtl/sdram_aref_ctrl.sv
// sdram_aref_ctrl: turns refresh-timer ticks into SDRAM AUTO REFRESH sequences.
//
// Each tick adds to a refresh-debt counter, which lets the arbiter postpone refreshes.
// While debt is pending the block requests the command bus. Once the bus is granted it
// issues an optional PRECHARGE ALL, then AREFs spaced by T_RFC until the debt is drained.
// At the end it releases the bus with a one-cycle done pulse.
//
// Build option:
//   AREF_PRECHARGE_EN - when defined, PRE + tRP wait precede the first AREF of each grant.
//                       When undefined, the grant cycle goes straight to AREF and sdr_a10 is 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   init_done    in   SDRAM power-up init complete; ticks are ignored while low
//   ref_tick     in   one-cycle pulse from the refresh timer
//   ref_grant    in   command bus grant, sampled only while requesting
//   reftime_en   out  registered init_done, enables the refresh timer
//   ref_req      out  command bus request
//   ref_urgent   out  registered (debt >= URGENT_LVL)
//   ref_done     out  one-cycle pulse when the sequence ends and the bus is released
//   ref_overflow out  sticky: a tick arrived while debt was saturated
//   sdr_cmd      out  {cs_n,ras_n,cas_n,we_n}: NOP=0111, PRE=0010, AREF=0001
//   sdr_a10      out  high during PRE (all banks)
module sdram_aref_ctrl #(
    parameter int unsigned T_RP       = 2,
    parameter int unsigned T_RFC      = 7,
    parameter int unsigned MAX_DEBT   = 8,
    parameter int unsigned URGENT_LVL = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       ref_tick,
    input  logic       ref_grant,
    output logic       reftime_en,
    output logic       ref_req,
    output logic       ref_urgent,
    output logic       ref_done,
    output logic       ref_overflow,
    output logic [3:0] sdr_cmd,
    output logic       sdr_a10
);

    localparam int unsigned DebtW = $clog2(MAX_DEBT + 1);
    localparam int unsigned TMax  = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int unsigned StepW = $clog2(TMax) + 1;

    localparam logic [3:0] CmdNop  = 4'b0111;
    localparam logic [3:0] CmdPre  = 4'b0010;
    localparam logic [3:0] CmdAref = 4'b0001;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StPre,
        StWaitRp,
        StAref,
        StWaitRfc,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [DebtW-1:0]   debt_q, debt_d;
    logic               overflow_q, overflow_d;
    logic               urgent_q, urgent_d;
    logic               ten_q, ten_d;
    logic               req_q, req_d;
    logic               done_q, done_d;
    logic [3:0]         cmd_q, cmd_d;
    logic               a10_q, a10_d;

    logic               tick_valid;
    logic               aref_issue;

    assign tick_valid = ref_tick & init_done;

    // Next state; outputs below are registered from state_d so each command
    // appears on the same edge the FSM enters its state.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        unique case (state_q)
            StIdle: begin
                if (debt_q != '0) state_d = StReq;
            end
            StReq: begin
                if (ref_grant) begin
`ifdef AREF_PRECHARGE_EN
                    state_d = StPre;
`else
                    state_d = StAref;
`endif
                end
            end
            StPre: begin
                if (T_RP > 1) begin
                    state_d = StWaitRp;
                    step_d  = StepW'(T_RP - 1);
                end else begin
                    state_d = StAref;
                end
            end
            StWaitRp: begin
                if (step_q <= StepW'(1)) state_d = StAref;
                else                     step_d  = step_q - StepW'(1);
            end
            StAref: begin
                // debt_q here is already net of the AREF just issued
                if (T_RFC > 1) begin
                    state_d = StWaitRfc;
                    step_d  = StepW'(T_RFC - 1);
                end else begin
                    state_d = (debt_q != '0) ? StAref : StDone;
                end
            end
            StWaitRfc: begin
                if (step_q <= StepW'(1)) state_d = (debt_q != '0) ? StAref : StDone;
                else                     step_d  = step_q - StepW'(1);
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign aref_issue = (state_d == StAref);

    always_comb begin
        debt_d     = debt_q;
        overflow_d = overflow_q;
        if (tick_valid && !aref_issue) begin
            if (debt_q == DebtW'(MAX_DEBT)) overflow_d = 1'b1;
            else                            debt_d     = debt_q + DebtW'(1);
        end else if (!tick_valid && aref_issue) begin
            debt_d = debt_q - DebtW'(1);
        end
    end

    always_comb begin
        ten_d    = init_done;
        urgent_d = (debt_q >= DebtW'(URGENT_LVL));
        req_d    = (state_d == StReq) || (state_d == StPre) || (state_d == StWaitRp) ||
                   (state_d == StAref) || (state_d == StWaitRfc);
        done_d   = (state_d == StDone);
        cmd_d    = CmdNop;
        if (state_d == StAref)     cmd_d = CmdAref;
        else if (state_d == StPre) cmd_d = CmdPre;
`ifdef AREF_PRECHARGE_EN
        a10_d    = (state_d == StPre);
`else
        a10_d    = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            step_q     <= '0;
            debt_q     <= '0;
            overflow_q <= 1'b0;
            urgent_q   <= 1'b0;
            ten_q      <= 1'b0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            cmd_q      <= CmdNop;
            a10_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            debt_q     <= debt_d;
            overflow_q <= overflow_d;
            urgent_q   <= urgent_d;
            ten_q      <= ten_d;
            req_q      <= req_d;
            done_q     <= done_d;
            cmd_q      <= cmd_d;
            a10_q      <= a10_d;
        end
    end

    assign reftime_en   = ten_q;
    assign ref_req      = req_q;
    assign ref_urgent   = urgent_q;
    assign ref_done     = done_q;
    assign ref_overflow = overflow_q;
    assign sdr_cmd      = cmd_q;
    assign sdr_a10      = a10_q;

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// tb_sdram_aref_ctrl: self-checking bench for sdram_aref_ctrl.
// Directed scenarios check event timing; a randomized run is checked cycle by cycle
// against a schedule-based reference model (deadlines in absolute cycle numbers).
// Honours AREF_PRECHARGE_EN the same way the design does.
module tb_sdram_aref_ctrl;

    localparam int T_RP       = 2;
    localparam int T_RFC      = 7;
    localparam int MAX_DEBT   = 8;
    localparam int URGENT_LVL = 6;
`ifdef AREF_PRECHARGE_EN
    localparam bit PreEn = 1'b1;
`else
    localparam bit PreEn = 1'b0;
`endif
    localparam logic [3:0] CmdNop  = 4'b0111;
    localparam logic [3:0] CmdPre  = 4'b0010;
    localparam logic [3:0] CmdAref = 4'b0001;

    // Cycle offsets after the tick edge for a lone tick with grant held high
    localparam int ExpPre  = PreEn ? 2 : -1;
    localparam int ExpAref = PreEn ? 2 + T_RP : 2;
    localparam int ExpDone = ExpAref + T_RFC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done = 1'b0;
    logic       ref_tick = 1'b0;
    logic       ref_grant = 1'b0;
    logic       reftime_en, ref_req, ref_urgent, ref_done, ref_overflow, sdr_a10;
    logic [3:0] sdr_cmd;

    always #5 clk = ~clk;

    sdram_aref_ctrl #(
        .T_RP       (T_RP),
        .T_RFC      (T_RFC),
        .MAX_DEBT   (MAX_DEBT),
        .URGENT_LVL (URGENT_LVL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .init_done    (init_done),
        .ref_tick     (ref_tick),
        .ref_grant    (ref_grant),
        .reftime_en   (reftime_en),
        .ref_req      (ref_req),
        .ref_urgent   (ref_urgent),
        .ref_done     (ref_done),
        .ref_overflow (ref_overflow),
        .sdr_cmd      (sdr_cmd),
        .sdr_a10      (sdr_a10)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 requesting, 2 owns bus, 3 releasing
    int         m_cyc = 0;
    int         m_debt = 0;
    bit         m_ovf = 1'b0;
    int         m_mode = 0;
    bit         m_first = 1'b0;
    int         m_pre_t = 0;
    int         m_last_aref = 0;
    logic [9:0] exp_vec = {CmdNop, 6'b0};

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic step();
        bit aref_now, pre_now, done_now, tv, urg;
        aref_now = 1'b0;
        pre_now  = 1'b0;
        done_now = 1'b0;
        if (rst) begin
            m_debt  = 0;
            m_ovf   = 1'b0;
            m_mode  = 0;
            m_first = 1'b0;
            exp_vec = {CmdNop, 6'b0};
        end else begin
            urg = (m_debt >= URGENT_LVL);
            case (m_mode)
                0: if (m_debt > 0) m_mode = 1;
                1: if (ref_grant) begin
                    m_mode = 2;
                    if (PreEn) begin
                        pre_now = 1'b1;
                        m_pre_t = m_cyc;
                        m_first = 1'b1;
                    end else begin
                        aref_now    = 1'b1;
                        m_last_aref = m_cyc;
                        m_first     = 1'b0;
                    end
                end
                2: if (m_first) begin
                    if (m_cyc == m_pre_t + T_RP) begin
                        aref_now    = 1'b1;
                        m_last_aref = m_cyc;
                        m_first     = 1'b0;
                    end
                end else if (m_cyc == m_last_aref + T_RFC) begin
                    if (m_debt > 0) begin
                        aref_now    = 1'b1;
                        m_last_aref = m_cyc;
                    end else begin
                        done_now = 1'b1;
                        m_mode   = 3;
                    end
                end
                default: m_mode = 0;
            endcase
            tv = ref_tick && init_done;
            if (tv && !aref_now) begin
                if (m_debt == MAX_DEBT) m_ovf = 1'b1;
                else                    m_debt++;
            end else if (!tv && aref_now) begin
                m_debt--;
            end
            exp_vec = {aref_now ? CmdAref : (pre_now ? CmdPre : CmdNop), pre_now,
                       (m_mode == 1 || m_mode == 2), done_now, urg, m_ovf, init_done};
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ref_tick  = 1'b0;
        ref_grant = 1'b0;
        init_done = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++; if (sdr_cmd !== CmdNop) begin n_fail++;
            $display("FAIL reset_cmd: got %b expected %b", sdr_cmd, CmdNop); end
        n_checks++; if ({reftime_en, ref_req, ref_urgent, ref_done, ref_overflow, sdr_a10} !== 6'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                {reftime_en, ref_req, ref_urgent, ref_done, ref_overflow, sdr_a10}); end
        // Mid-stream: start a sequence, then hold reset for 3 cycles
        rst = 1'b0; init_done = 1'b1; ref_grant = 1'b1; ref_tick = 1'b1;
        step();
        ref_tick = 1'b0;
        repeat (ExpAref) step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        n_checks++; if (sdr_cmd !== CmdNop) begin n_fail++;
            $display("FAIL reset_mid_cmd: got %b expected %b", sdr_cmd, CmdNop); end
        n_checks++; if ({ref_req, ref_done, ref_overflow} !== 3'b0) begin n_fail++;
            $display("FAIL reset_mid_flags: got %b expected 000", {ref_req, ref_done, ref_overflow});
        end
        n_checks++; if (dut.debt_q !== 4'd0) begin n_fail++;
            $display("FAIL reset_mid_debt: got %0d expected 0", dut.debt_q); end
    endtask

    task automatic test_single();
        int t_req, t_pre, t_aref, t_done, n_aref;
        bit a10_seen;
        t_req = -1; t_pre = -1; t_aref = -1; t_done = -1; n_aref = 0; a10_seen = 1'b0;
        do_reset();
        ref_grant = 1'b1;
        ref_tick  = 1'b1;
        step();
        ref_tick = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (ref_req && t_req < 0) t_req = k;
            if (sdr_cmd == CmdPre && t_pre < 0) t_pre = k;
            if (sdr_cmd == CmdAref) begin n_aref++; if (t_aref < 0) t_aref = k; end
            if (ref_done && t_done < 0) t_done = k;
            if (sdr_a10) a10_seen = 1'b1;
        end
        n_checks++; if (t_req !== 1) begin n_fail++;
            $display("FAIL single_req_time: got %0d expected 1", t_req); end
        n_checks++; if (t_pre !== ExpPre) begin n_fail++;
            $display("FAIL single_pre_time: got %0d expected %0d", t_pre, ExpPre); end
        n_checks++; if (a10_seen !== PreEn) begin n_fail++;
            $display("FAIL single_a10: got %0d expected %0d", a10_seen, PreEn); end
        n_checks++; if (t_aref !== ExpAref) begin n_fail++;
            $display("FAIL single_aref_time: got %0d expected %0d", t_aref, ExpAref); end
        n_checks++; if (n_aref !== 1) begin n_fail++;
            $display("FAIL single_aref_count: got %0d expected 1", n_aref); end
        n_checks++; if (t_done !== ExpDone) begin n_fail++;
            $display("FAIL single_done_time: got %0d expected %0d", t_done, ExpDone); end
        n_checks++; if (ref_req !== 1'b0) begin n_fail++;
            $display("FAIL single_idle_after: got req=%b expected 0", ref_req); end
    endtask

    task automatic test_multi_tick();
        int n_pre, n_aref, n_done, last, bad_gap, t_pre, t_first;
        n_pre = 0; n_aref = 0; n_done = 0; last = -1; bad_gap = 0; t_pre = -1; t_first = -1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ref_tick = 1'b1; step(); ref_tick = 1'b0; step();
        end
        repeat (3) step();
        n_checks++; if (ref_req !== 1'b1) begin n_fail++;
            $display("FAIL multi_req_wait: got %b expected 1", ref_req); end
        for (int k = 0; k < 45; k++) begin
            ref_grant = (k == 0);
            step();
            if (sdr_cmd == CmdPre) begin n_pre++; t_pre = k; end
            if (sdr_cmd == CmdAref) begin
                if (last >= 0 && k - last != T_RFC) bad_gap++;
                if (t_first < 0) t_first = k;
                last = k;
                n_aref++;
            end
            if (ref_done) n_done++;
        end
        n_checks++; if (n_pre !== (PreEn ? 1 : 0)) begin n_fail++;
            $display("FAIL multi_pre_count: got %0d expected %0d", n_pre, PreEn ? 1 : 0); end
        n_checks++; if (n_aref !== 3) begin n_fail++;
            $display("FAIL multi_aref_count: got %0d expected 3", n_aref); end
        n_checks++; if (bad_gap !== 0) begin n_fail++;
            $display("FAIL multi_aref_gap: got %0d bad gaps expected 0", bad_gap); end
        if (PreEn) begin
            n_checks++; if (t_first - t_pre !== T_RP) begin n_fail++;
                $display("FAIL multi_pre_to_aref: got %0d expected %0d", t_first - t_pre, T_RP);
            end
        end
        n_checks++; if (n_done !== 1) begin n_fail++;
            $display("FAIL multi_done_count: got %0d expected 1", n_done); end
        n_checks++; if (dut.debt_q !== 4'd0) begin n_fail++;
            $display("FAIL multi_debt_end: got %0d expected 0", dut.debt_q); end
    endtask

    task automatic test_tick_on_aref();
        int n_aref, n_done, t_second;
        n_aref = 0; n_done = 0; t_second = -1;
        do_reset();
        ref_grant = 1'b1;
        ref_tick  = 1'b1;
        step();
        ref_tick = 1'b0;
        for (int k = 1; k <= ExpAref; k++) begin
            ref_tick = (k == ExpAref);
            step();
        end
        ref_tick = 1'b0;
        n_checks++; if (sdr_cmd !== CmdAref) begin n_fail++;
            $display("FAIL tickaref_cmd: got %b expected %b", sdr_cmd, CmdAref); end
        n_checks++; if (dut.debt_q !== 4'd1) begin n_fail++;
            $display("FAIL tickaref_debt: got %0d expected 1", dut.debt_q); end
        for (int k = 1; k <= 25; k++) begin
            step();
            if (sdr_cmd == CmdAref) begin n_aref++; if (t_second < 0) t_second = k; end
            if (ref_done) n_done++;
        end
        n_checks++; if (n_aref !== 1) begin n_fail++;
            $display("FAIL tickaref_extra: got %0d expected 1", n_aref); end
        n_checks++; if (t_second !== T_RFC) begin n_fail++;
            $display("FAIL tickaref_spacing: got %0d expected %0d", t_second, T_RFC); end
        n_checks++; if (n_done !== 1) begin n_fail++;
            $display("FAIL tickaref_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_saturation();
        int n_aref, exp_debt;
        n_aref = 0;
        do_reset();
        for (int i = 1; i <= MAX_DEBT + 1; i++) begin
            ref_tick = 1'b1;
            step();
            exp_debt = (i > MAX_DEBT) ? MAX_DEBT : i;
            n_checks++; if (ref_urgent !== ((i - 1) >= URGENT_LVL)) begin n_fail++;
                $display("FAIL sat_urgent_%0d: got %b expected %b", i, ref_urgent,
                         ((i - 1) >= URGENT_LVL)); end
            n_checks++; if (ref_overflow !== (i > MAX_DEBT)) begin n_fail++;
                $display("FAIL sat_overflow_%0d: got %b expected %b", i, ref_overflow,
                         (i > MAX_DEBT)); end
            n_checks++; if (dut.debt_q !== 4'(exp_debt)) begin n_fail++;
                $display("FAIL sat_debt_%0d: got %0d expected %0d", i, dut.debt_q, exp_debt); end
        end
        ref_tick = 1'b0;
        for (int k = 0; k < 80; k++) begin
            ref_grant = (k == 0);
            step();
            if (sdr_cmd == CmdAref) n_aref++;
        end
        n_checks++; if (n_aref !== MAX_DEBT) begin n_fail++;
            $display("FAIL sat_drain_count: got %0d expected %0d", n_aref, MAX_DEBT); end
        n_checks++; if ({ref_overflow, ref_urgent} !== 2'b10) begin n_fail++;
            $display("FAIL sat_sticky: got ovf,urg=%b expected 10", {ref_overflow, ref_urgent}); end
    endtask

    task automatic test_reset_mid_rfc();
        int n_bad;
        n_bad = 0;
        do_reset();
        ref_grant = 1'b1;
        ref_tick  = 1'b1;
        step();
        ref_tick = 1'b0;
        repeat (ExpAref + 2) step();
        n_checks++; if (ref_req !== 1'b1) begin n_fail++;
            $display("FAIL rstrfc_busy: got req=%b expected 1", ref_req); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if ({sdr_cmd, ref_req, ref_done} !== {CmdNop, 2'b00}) begin n_fail++;
            $display("FAIL rstrfc_outputs: got %b expected %b", {sdr_cmd, ref_req, ref_done},
                     {CmdNop, 2'b00}); end
        repeat (15) begin
            step();
            if (ref_done || ref_req || sdr_cmd != CmdNop) n_bad++;
        end
        n_checks++; if (n_bad !== 0) begin n_fail++;
            $display("FAIL rstrfc_quiet: got %0d active cycles expected 0", n_bad); end
    endtask

    task automatic test_init_gate();
        do_reset();
        init_done = 1'b0;
        step();
        n_checks++; if (reftime_en !== 1'b0) begin n_fail++;
            $display("FAIL init_ten_low: got %b expected 0", reftime_en); end
        repeat (3) begin ref_tick = 1'b1; step(); end
        ref_tick = 1'b0;
        repeat (3) step();
        n_checks++; if ({ref_req, dut.debt_q} !== 5'b0) begin n_fail++;
            $display("FAIL init_ticks_ignored: got req=%b debt=%0d expected 0/0", ref_req,
                     dut.debt_q); end
        init_done = 1'b1;
        step();
        n_checks++; if (reftime_en !== 1'b1) begin n_fail++;
            $display("FAIL init_ten_high: got %b expected 1", reftime_en); end
    endtask

    task automatic test_random();
        logic [9:0] act;
        int         grant_pct;
        grant_pct = 50;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 300 == 0) grant_pct = $urandom_range(2, 90);
            ref_tick  = ($urandom_range(0, 9) == 0);
            ref_grant = ($urandom_range(0, 99) < grant_pct);
            init_done = ($urandom_range(0, 99) != 0);
            rst       = ($urandom_range(0, 599) == 0);
            step();
            act = {sdr_cmd, sdr_a10, ref_req, ref_done, ref_urgent, ref_overflow, reftime_en};
            n_checks++; if (act !== exp_vec || dut.debt_q !== 4'(m_debt)) begin n_fail++;
                $display("FAIL random_cycle_%0d: got %b debt %0d expected %b debt %0d", k, act,
                         dut.debt_q, exp_vec, m_debt); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_tick();
        test_tick_on_aref();
        test_saturation();
        test_reset_mid_rfc();
        test_init_gate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
